kf6845_timing_axis: RTL
=======================

KF6845_TIMING_AXIS -- requirements
Module: kf6845_timing_axis

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, 8, width of the counter, data bus and total/displayed/sync-position registers (min 4).
REQ-002 SHALL have parameter SYNC_WIDTH_BITS, 4, width of the sync-width register (<= COUNT_WIDTH).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port video_clock_enable  input  1  counting qualifier; one count step per high cycle.
REQ-006 SHALL have port internal_data_bus  input  COUNT_WIDTH  register write data.
REQ-007 SHALL have ports write_total_register, write_displayed_register, write_sync_position_register, write_sync_width_register, write_control_register  input  1 each  write strobes, one register per strobe.
REQ-008 SHALL have port character_count  output  COUNT_WIDTH  current position counter.
REQ-009 SHALL have ports Period_Half, Period_End  output  1 each  single-cycle position pulses.
REQ-010 SHALL have port Display  output  1  skewed display-enable.
REQ-011 SHALL have port SYNC  output  1  sync pulse, polarity per control register.

Function
REQ-012 SHALL hold pending registers (total, displayed, sync_position, sync_width, control) written on the cycle their strobe is high; sync_width takes bus[SYNC_WIDTH_BITS-1:0]; control takes bus[3:0].
REQ-013 SHALL use control bit0 = immediate update, bit1 = sync invert, bits3:2 = display skew 0-3.
REQ-014 SHALL copy all pending registers to active registers on every Period_End cycle; with control bit0 set, SHALL also copy on the cycle after any write.
REQ-015 SHALL commit pre-write pending values when a write and Period_End coincide; the new value commits at the next Period_End.
REQ-016 SHALL compute everything below from active registers only; control itself is always applied one cycle after writing, independent of bit0.
REQ-017 SHALL hold character_count when video_clock_enable is low; when high, count==total -> 0, else count+1.
REQ-018 SHALL assert Period_End combinationally when video_clock_enable high and count==total.
REQ-019 SHALL assert Period_Half combinationally when video_clock_enable high and count==(total>>1).
REQ-020 SHALL form raw display = (count < displayed) and delay it by skew count_enable-qualified stages; skew 0 = combinational pass-through.
REQ-021 SHALL run a sync FSM IDLE/ACTIVE: IDLE->ACTIVE on enable with count==sync_position and sync_width!=0, loading a down-counter with sync_width; ACTIVE decrements per enable, ->IDLE when it reaches 1 and enable high.
REQ-022 SHALL drive SYNC = (state==ACTIVE) XOR control bit1, registered; pulse length exactly sync_width enabled cycles.
REQ-023 Boundaries: total=0 -> count stays 0, Period_End every enabled cycle; displayed>total -> Display continuously high; displayed=0 -> Display low; sync_position>total -> no sync; sync_width=0 -> no sync; sync spanning wrap SHALL continue across wrap; sync_position hit while ACTIVE SHALL be ignored.

Reset
REQ-024 SHALL on reset clear all pending/active registers, counter, skew pipeline and sync down-counter to 0, FSM to IDLE.
REQ-025 SHALL drive after reset: character_count=0, Display=0, SYNC=0; Period_End/Period_Half follow REQ-018/019 (total=0) once reset releases.
REQ-026 Reset mid-pulse SHALL terminate sync and display immediately on the next edge.

Structure
REQ-027 SHALL place control bit positions, skew width and sync FSM state enum in shared package kf6845_pkg.
REQ-028 SHALL implement the skew delay as sub-module kf6845_skew_delay (select-driven 0-3 stage enable-qualified delay).

Verification
REQ-029 Reset, enable toggling every cycle, no writes -> count stays 0, Period_End on every enabled cycle, Display=0, SYNC=0.
REQ-030 Write total=100, displayed=60, sync_pos=70, width=10, control=1 -> period 101 enabled steps, Display high counts 0-59, SYNC high 10 enabled steps starting count 70, Period_Half at count 50.
REQ-031 Same with control=0 -> values take effect only after first Period_End; prior period unchanged.
REQ-032 Control=0b1110 (invert, skew 3) -> SYNC low during pulse else high; Display delayed 3 enabled steps.
REQ-033 sync_pos=98, width=10, total=100 -> SYNC spans wrap, ends at count 6 of next period.
REQ-034 Assert reset at count 72 during sync -> SYNC=0, count=0 on next edge; write to total coincident with Period_End -> commit next period.

Source files
------------

// File: rtl/kf6845_pkg.sv
// kf6845_pkg -- shared definitions for the kf6845 timing axis.
// Holds the control-register bit map, the display skew select width and
// the sync pulse FSM state type used by the top and its skew sub-module.
package kf6845_pkg;

  // Control register layout (4 bits wide)
  localparam int CTRL_W       = 4;
  localparam int CTRL_IMM     = 0;  // copy pending->active the cycle after any write
  localparam int CTRL_INV     = 1;  // invert SYNC polarity
  localparam int CTRL_SKEW_LO = 2;  // display skew select, bits [3:2]
  localparam int SKEW_W       = 2;  // skew select width (0..3 stages)
  localparam int SKEW_MAX     = (1 << SKEW_W) - 1;

  typedef enum logic {
    SYNC_IDLE   = 1'b0,
    SYNC_ACTIVE = 1'b1
  } sync_state_t;

endpackage

// File: rtl/kf6845_skew_delay.sv
// kf6845_skew_delay -- select-driven 0..3 stage delay for the display enable.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   enable       : pipeline advances only on enabled cycles
//   sel          : number of stages of delay (0 = combinational pass-through)
//   din / dout   : raw display enable in, skewed display enable out
module kf6845_skew_delay
  import kf6845_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [SKEW_W-1:0] sel,
  input  logic              din,
  output logic              dout
);

  logic [SKEW_MAX-1:0] pipe;

  always_ff @(posedge clock) begin
    if (reset)       pipe <= '0;
    else if (enable) pipe <= {pipe[SKEW_MAX-2:0], din};
  end

  // pipe[k] holds din as it was k+1 enabled steps ago
  always_comb begin
    dout = din;
    case (sel)
      2'd0:    dout = din;
      2'd1:    dout = pipe[0];
      2'd2:    dout = pipe[1];
      default: dout = pipe[2];
    endcase
  end

endmodule

// File: rtl/kf6845_timing_axis.sv
// kf6845_timing_axis -- one axis (horizontal or vertical) of a 6845-style
// CRT timing generator: position counter, period pulses, skewed display
// enable and a programmable sync pulse.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   video_clock_enable       : one count step per high cycle
//   internal_data_bus        : register write data
//   write_*_register         : one write strobe per register
//   character_count          : current position
//   Period_Half, Period_End  : combinational position pulses
//   Display                  : skewed display enable
//   SYNC                     : registered sync pulse, polarity from control
module kf6845_timing_axis
  import kf6845_pkg::*;
#(
  parameter int COUNT_WIDTH     = 8,
  parameter int SYNC_WIDTH_BITS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   video_clock_enable,
  input  logic [COUNT_WIDTH-1:0] internal_data_bus,
  input  logic                   write_total_register,
  input  logic                   write_displayed_register,
  input  logic                   write_sync_position_register,
  input  logic                   write_sync_width_register,
  input  logic                   write_control_register,
  output logic [COUNT_WIDTH-1:0] character_count,
  output logic                   Period_Half,
  output logic                   Period_End,
  output logic                   Display,
  output logic                   SYNC
);

  // Pending (host-visible) and active (timing-visible) register sets
  logic [COUNT_WIDTH-1:0]     pend_total, pend_disp, pend_pos;
  logic [SYNC_WIDTH_BITS-1:0] pend_width;
  logic [CTRL_W-1:0]          pend_ctrl;
  logic [COUNT_WIDTH-1:0]     act_total, act_disp, act_pos;
  logic [SYNC_WIDTH_BITS-1:0] act_width;
  logic [CTRL_W-1:0]          act_ctrl;

  logic write_d, ctrl_write_d, commit_all;
  logic [COUNT_WIDTH-1:0] count;
  logic raw_display;

  sync_state_t                state, state_n;
  logic [SYNC_WIDTH_BITS-1:0] sync_cnt, sync_cnt_n;
  logic                       sync_q;

  // ---------------- register file ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_total   <= '0;
      pend_disp    <= '0;
      pend_pos     <= '0;
      pend_width   <= '0;
      pend_ctrl    <= '0;
      write_d      <= 1'b0;
      ctrl_write_d <= 1'b0;
    end else begin
      if (write_total_register)         pend_total <= internal_data_bus;
      if (write_displayed_register)     pend_disp  <= internal_data_bus;
      if (write_sync_position_register) pend_pos   <= internal_data_bus;
      if (write_sync_width_register)    pend_width <= internal_data_bus[SYNC_WIDTH_BITS-1:0];
      if (write_control_register)       pend_ctrl  <= internal_data_bus[CTRL_W-1:0];
      write_d      <= write_total_register | write_displayed_register |
                      write_sync_position_register | write_sync_width_register |
                      write_control_register;
      ctrl_write_d <= write_control_register;
    end
  end

  // Immediate mode is judged on the freshly written control value, so a
  // control write that sets bit0 also pulls in everything written before it.
  // A write landing on Period_End is not yet in pending, so the old value
  // commits and the new one waits for the next Period_End.
  assign commit_all = Period_End | (write_d & pend_ctrl[CTRL_IMM]);

  always_ff @(posedge clock) begin
    if (reset) begin
      act_total <= '0;
      act_disp  <= '0;
      act_pos   <= '0;
      act_width <= '0;
      act_ctrl  <= '0;
    end else if (commit_all) begin
      act_total <= pend_total;
      act_disp  <= pend_disp;
      act_pos   <= pend_pos;
      act_width <= pend_width;
      act_ctrl  <= pend_ctrl;
    end else if (ctrl_write_d) begin
      act_ctrl  <= pend_ctrl;
    end
  end

  // ---------------- position counter ----------------
  assign Period_End  = video_clock_enable && (count == act_total);
  assign Period_Half = video_clock_enable && (count == (act_total >> 1));

  always_ff @(posedge clock) begin
    if (reset)                   count <= '0;
    else if (Period_End)         count <= '0;
    else if (video_clock_enable) count <= count + COUNT_WIDTH'(1);
  end

  assign character_count = count;

  // ---------------- display enable ----------------
  assign raw_display = (count < act_disp);

  kf6845_skew_delay u_skew (
    .clock  (clock),
    .reset  (reset),
    .enable (video_clock_enable),
    .sel    (act_ctrl[CTRL_SKEW_LO +: SKEW_W]),
    .din    (raw_display),
    .dout   (Display)
  );

  // ---------------- sync pulse FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SYNC_IDLE;
      sync_cnt <= '0;
      sync_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sync_cnt <= sync_cnt_n;
      sync_q   <= (state_n == SYNC_ACTIVE) ^ act_ctrl[CTRL_INV];
    end
  end

  // Position hits while ACTIVE are ignored; the down-counter carries the
  // pulse across a counter wrap untouched.
  always_comb begin
    state_n    = state;
    sync_cnt_n = sync_cnt;
    case (state)
      SYNC_IDLE: begin
        if (video_clock_enable && (count == act_pos) && (act_width != '0)) begin
          state_n    = SYNC_ACTIVE;
          sync_cnt_n = act_width;
        end
      end
      default: begin
        if (video_clock_enable) begin
          sync_cnt_n = sync_cnt - SYNC_WIDTH_BITS'(1);
          if (sync_cnt == SYNC_WIDTH_BITS'(1)) state_n = SYNC_IDLE;
        end
      end
    endcase
  end

  assign SYNC = sync_q;

endmodule
